instr_encoder: RTL and testbench

Sequential MIPS instruction encoder: the inverse of the single-cycle control decoder. It accepts mnemonic-level instruction requests over a valid/ready handshake and packs each one into a 32-bit MIPS word. It then streams the words into the instruction memory through a write port at consecutive word addresses. It sits between the test/boot loader and the instruction memory of the single-cycle CPU, and its encodings match exactly what the decoder accepts.

---
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder.sv | 126 ++++++++++++
 tb/tb_instr_encoder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder_if
//  Brief    : Request handshake bundle carrying mnemonic-level instructions
//             from the loader (master) into the encoder (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    // Loader side: drives the request and observes ready.
    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready
    );

    // Encoder side: consumes the request and drives ready.
    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Brief    : Packs mnemonic-level MIPS requests into 32-bit instruction
//             words and streams them into instruction memory at consecutive
//             word addresses, flagging illegal mnemonic codes.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int IM_DEPTH = 128,
    parameter int AW       = 7
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    instr_encoder_if.slave     req,
    output logic               im_we,
    output logic [AW-1:0]      im_addr,
    output logic [31:0]        im_wdata,
    output logic [AW:0]        count,
    output logic               full,
    output logic               err,
    output logic [4:0]         err_mnem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [AW:0] c_depth = (AW+1)'(IM_DEPTH);
    localparam logic [AW:0] c_one   = (AW+1)'(1);

    state_t        state_q;
    logic          im_we_q;
    logic [AW-1:0] im_addr_q;
    logic [31:0]   im_wdata_q;
    logic [AW:0]   count_q;
    logic          err_q;
    logic [4:0]    err_mnem_q;

    logic          w_hs;
    logic          legal_d;
    logic [31:0]   word_d;

    // start pre-empts any request presented in its own cycle.
    assign req.in_ready = (state_q == S_LOAD) & ~start;
    assign w_hs         = req.in_valid & req.in_ready;

    // Encode the presented request; codes above nop are flagged illegal.
    always_comb begin
        legal_d = 1'b1;
        word_d  = 32'h0000_0000;
        case (req.in_mnem)
            5'd0:  word_d = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'h00, 6'h20};
            5'd1:  word_d = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'h00, 6'h22};
            5'd2:  word_d = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'h00, 6'h24};
            5'd3:  word_d = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'h00, 6'h25};
            5'd4:  word_d = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'h00, 6'h2A};
            5'd5:  word_d = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'h00, 6'h2B};
            5'd6:  word_d = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'h00, 6'h21};
            5'd7:  word_d = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'h00, 6'h23};
            5'd8:  word_d = {6'h08, req.in_rs, req.in_rt, req.in_imm};
            5'd9:  word_d = {6'h0D, req.in_rs, req.in_rt, req.in_imm};
            5'd10: word_d = {6'h23, req.in_rs, req.in_rt, req.in_imm};
            5'd11: word_d = {6'h2B, req.in_rs, req.in_rt, req.in_imm};
            5'd12: word_d = {6'h04, req.in_rs, req.in_rt, req.in_imm};
            5'd13: word_d = {6'h0C, req.in_rs, req.in_rt, req.in_imm};
            5'd14: word_d = {6'h02, req.in_target};
            5'd15: word_d = {6'h03, req.in_target};
            5'd16: word_d = 32'h0000_0000;
            default: begin
                legal_d = 1'b0;
                word_d  = 32'h0000_0000;
            end
        endcase
    end

    // Load-control FSM with registered write port, counter and error capture.
    // The write pointer is the low bits of count: illegal requests move neither.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'h0000_0000;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_mnem_q <= 5'd0;
        end else begin
            im_we_q <= 1'b0;
            if (start) begin
                state_q    <= S_LOAD;
                count_q    <= '0;
                err_q      <= 1'b0;
                err_mnem_q <= 5'd0;
            end else if (w_hs) begin
                if (legal_d) begin
                    im_we_q    <= 1'b1;
                    im_addr_q  <= count_q[AW-1:0];
                    im_wdata_q <= word_d;
                    count_q    <= count_q + c_one;
                    if ((count_q + c_one) == c_depth) begin
                        state_q <= S_FULL;
                    end
                end else begin
                    err_q <= 1'b1;
                    if (!err_q) begin
                        err_mnem_q <= req.in_mnem;
                    end
                end
            end
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign count    = count_q;
    assign full     = (state_q == S_FULL);
    assign err      = err_q;
    assign err_mnem = err_mnem_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Brief    : Self-checking bench for instr_encoder: directed scenarios plus
//             randomized requests against a table-driven reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
    localparam int IM_DEPTH = 128;
    localparam int AW       = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;
    logic [4:0]    err_mnem;

    instr_encoder_if bus ();

    instr_encoder #(.IM_DEPTH(IM_DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .req      (bus),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .count    (count),
        .full     (full),
        .err      (err),
        .err_mnem (err_mnem)
    );

    always #5 clk = ~clk;

    // Instruction memory as the CPU would see it.
    logic [31:0] dut_mem [IM_DEPTH];
    always @(posedge clk) begin
        if (im_we) dut_mem[im_addr] <= im_wdata;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [5:0]  funct_tab [8];
    logic [5:0]  op_tab    [6];
    int          m_count;
    bit          m_armed;
    bit          m_err;
    logic [4:0]  m_err_mnem;
    bit          e_we;
    logic [6:0]  e_addr;
    logic [31:0] e_wdata;
    logic [31:0] exp_mem     [IM_DEPTH];
    bit          exp_written [IM_DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_enc(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg,
                                    output bit legal, output logic [31:0] w);
        int code;
        code  = int'(mn);
        legal = 1'b1;
        w     = 32'h0;
        if (code < 8)       w = {6'h00, rs, rt, rd, 5'h00, funct_tab[code]};
        else if (code < 14) w = {op_tab[code-8], rs, rt, imm};
        else if (code == 14) w = {6'h02, tg};
        else if (code == 15) w = {6'h03, tg};
        else if (code == 16) w = 32'h0;
        else legal = 1'b0;
    endfunction

    task automatic check_outputs();
        chk("im_we", im_we, e_we);
        if (e_we) begin
            chk("im_addr", im_addr, e_addr);
            chk("im_wdata", im_wdata, e_wdata);
        end
        chk("count", count, m_count);
        chk("full", full, (m_count == IM_DEPTH));
        chk("err", err, m_err);
        chk("err_mnem", err_mnem, m_err_mnem);
    endtask

    // One clock of stimulus: drive, check ready, advance model, check outputs.
    task automatic cycle(input bit st, input bit v, input logic [4:0] mn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input logic [25:0] tg);
        bit          rdy;
        bit          legal;
        logic [31:0] w;
        start         = st;
        bus.in_valid  = v;
        bus.in_mnem   = mn;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = tg;
        #2;
        rdy = m_armed && (m_count < IM_DEPTH) && !st;
        chk("in_ready", bus.in_ready, rdy);
        // The write registered last cycle lands in memory at this edge.
        if (e_we) begin
            exp_mem[e_addr]     = e_wdata;
            exp_written[e_addr] = 1'b1;
        end
        e_we = 1'b0;
        if (st) begin
            m_count    = 0;
            m_err      = 1'b0;
            m_err_mnem = 5'd0;
            m_armed    = 1'b1;
        end else if (v && rdy) begin
            ref_enc(mn, rs, rt, rd, imm, tg, legal, w);
            if (legal) begin
                e_we    = 1'b1;
                e_addr  = m_count[6:0];
                e_wdata = w;
                m_count++;
            end else begin
                if (!m_err) m_err_mnem = mn;
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    endtask

    initial begin
        funct_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h21, 6'h23};
        op_tab    = '{6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0C};
        for (int i = 0; i < IM_DEPTH; i++) exp_written[i] = 1'b0;
        m_count = 0; m_armed = 1'b0; m_err = 1'b0; m_err_mnem = 5'd0;
        e_we = 1'b0; e_addr = 7'd0; e_wdata = 32'h0;

        rst = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_mnem = 5'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
        bus.in_rd = 5'd0; bus.in_imm = 16'h0; bus.in_target = 26'h0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_im_we", im_we, 1'b0);
        chk("rst_im_addr", im_addr, 32'h0);
        chk("rst_im_wdata", im_wdata, 32'h0);
        chk("rst_count", count, 32'h0);
        chk("rst_full", full, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_mnem", err_mnem, 32'h0);
        rst = 1'b0;

        // Idle without start: nothing accepted
        cycle(0, 1, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);

        // add r3 = r1 + r2
        cycle(1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        cycle(0, 1, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        chk("add_word", im_wdata, 32'h0022_1820);
        chk("add_addr", im_addr, 32'h0);
        chk("add_count", count, 32'd1);

        // lw then jal back-to-back
        cycle(1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        cycle(0, 1, 5'd10, 5'd29, 5'd8, 5'd0, 16'hFFFC, 26'h0);
        chk("lw_word", im_wdata, 32'h8FA8_FFFC);
        cycle(0, 1, 5'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0004);
        chk("jal_word", im_wdata, 32'h0C10_0004);
        chk("jal_addr", im_addr, 32'd1);
        chk("jal_count", count, 32'd2);

        // Fill with nops, then the held 129th request
        cycle(1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        for (int i = 0; i < IM_DEPTH; i++) cycle(0, 1, 5'd16, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0);
        chk("fill_full", full, 1'b1);
        chk("fill_last_addr", im_addr, 32'd127);
        cycle(0, 1, 5'd16, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0);
        chk("held_ready", bus.in_ready, 1'b0);
        chk("held_no_we", im_we, 1'b0);
        // start with valid in the same cycle: not accepted, then accepted
        cycle(1, 1, 5'd16, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        chk("start_hs_no_we", im_we, 1'b0);
        cycle(0, 1, 5'd16, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        chk("rearm_addr", im_addr, 32'd0);

        // Illegal code between two legal requests
        cycle(1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        cycle(0, 1, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        cycle(0, 1, 5'd20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        cycle(0, 1, 5'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        chk("sub_word", im_wdata, 32'h0085_3022);
        chk("sub_addr", im_addr, 32'd1);
        chk("illegal_err_mnem", err_mnem, 32'd20);
        chk("illegal_count", count, 32'd2);
        cycle(0, 1, 5'd25, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);

        // Asynchronous reset while a write is in flight
        cycle(1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        cycle(0, 1, 5'd2, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0);
        chk("pre_rst_we", im_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_we", im_we, 1'b0);
        chk("async_count", count, 32'h0);
        chk("async_ready", bus.in_ready, 1'b0);
        chk("async_err", err, 1'b0);
        m_count = 0; m_armed = 1'b0; m_err = 1'b0; m_err_mnem = 5'd0; e_we = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(0, 1, 5'd3, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);

        // Randomized requests with occasional re-start
        cycle(1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 19)), 5'($urandom), 5'($urandom), 5'($urandom),
                  16'($urandom), 26'($urandom));
        end
        idle(2);

        // Memory image as seen by the CPU
        for (int i = 0; i < IM_DEPTH; i++) begin
            if (exp_written[i]) chk($sformatf("mem[%0d]", i), dut_mem[i], exp_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
